pc_unit: RTL

Parametrised program-counter unit for the monocycle MIPS CPU: holds the PC register and selects the next PC among sequential, branch, jump, jump-register, exception and exception-return targets. Adds stall, a reset vector, an exception PC (EPC) register and a retired-instruction counter. Sits between the control/ALU outputs and the instruction memory address input.

---
 rtl/pc_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter unit for the monocycle MIPS CPU.
//
// Holds the PC register and selects the next PC. The candidate targets are:
// sequential, branch, jump, jump-register, exception and exception-return.
// The unit also provides stall, a reset vector, an exception PC (EPC)
// register and a retired-instruction counter. All state changes on the
// FALLING edge of clk, so instruction memory can read on the rising edge
// against a PC that has been stable for half a cycle.
//
// Build option:
//   PC_ALIGN_CHECK_EN  when defined, a jr/eret target with bits [1:0] != 0
//                      raises an exception instead of being loaded, and
//                      addr_err pulses for one cycle. When undefined,
//                      targets load verbatim and addr_err is tied to 0.
//
// Ports:
//   clk            single clock (state updates on negedge)
//   rst            synchronous active-high reset, sampled on negedge
//   stall          hold PC, EPC and counter (an exception still wins)
//   branch_taken   conditional branch resolved taken
//   branch_offset  signed word offset (imm16)
//   jump           J/JAL
//   jump_index     26-bit instruction index
//   jr             JR/JALR
//   jr_target      register-sourced target
//   exc            exception request
//   eret           return from exception
//   pc_out         current PC
//   pc_plus4       pc_out + 4, combinational (link address)
//   epc_out        saved exception PC
//   instr_count    retired-instruction count (wraps)
//   addr_err       registered misaligned-target flag
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned            WIDTH        = 32,
  parameter logic [WIDTH-1:0]       RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0]       EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int unsigned            CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_offset,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 jr,
  input  logic [WIDTH-1:0]     jr_target,
  input  logic                 exc,
  input  logic                 eret,
  output logic [WIDTH-1:0]     pc_out,
  output logic [WIDTH-1:0]     pc_plus4,
  output logic [WIDTH-1:0]     epc_out,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 addr_err
);

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_JR,
    SRC_ERET,
    SRC_EXC,
    SRC_HOLD
  } pc_src_e;

  logic [WIDTH-1:0]     pc_q;
  logic [WIDTH-1:0]     epc_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  pc_src_e              src;
  logic [WIDTH-1:0]     next_target;
  logic [WIDTH-1:0]     branch_disp;
  logic                 align_fault;
  logic                 take_exc;
  logic                 advance;

  assign pc_out      = pc_q;
  assign epc_out     = epc_q;
  assign instr_count = cnt_q;
  assign pc_plus4    = pc_q + WIDTH'(4);

  // Sign-extended word offset, scaled to a byte displacement.
  assign branch_disp = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

  // Source priority: exc beats stall, and stall drops every other redirect.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    src         = SRC_SEQ;
    next_target = pc_plus4;
    if (exc)               src = SRC_EXC;
    else if (stall)        src = SRC_HOLD;
    else if (eret)         src = SRC_ERET;
    else if (jr)           src = SRC_JR;
    else if (jump)         src = SRC_JUMP;
    else if (branch_taken) src = SRC_BRANCH;

    case (src)
      SRC_BRANCH: next_target = pc_plus4 + branch_disp;
      SRC_JUMP:   next_target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
      SRC_JR:     next_target = jr_target;
      SRC_ERET:   next_target = epc_q;
      SRC_EXC:    next_target = EXC_VECTOR;
      SRC_HOLD:   next_target = pc_q;
      default:    next_target = pc_plus4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // A misaligned register/EPC target turns into an exception on the
  // instruction that requested it.
  assign align_fault = ((src == SRC_JR) || (src == SRC_ERET)) &&
                       (next_target[1:0] != 2'b00);

  logic addr_err_q;
  always_ff @(negedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= align_fault;
  end
  assign addr_err = addr_err_q;
`else
  assign align_fault = 1'b0;
  assign addr_err    = 1'b0;
`endif

  assign take_exc = (src == SRC_EXC) || align_fault;
  assign advance  = !take_exc && (src != SRC_HOLD);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others (epc captures the old pc).
  always_ff @(negedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      cnt_q <= '0;
    end else if (take_exc) begin
      epc_q <= pc_q;
      pc_q  <= EXC_VECTOR;
    end else if (advance) begin
      pc_q  <= next_target;
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule
